// File: rtl/wb_regfile_pkg.sv
// rtl/wb_regfile_pkg.sv - shared widths and register-file constants for the writeback stage
package wb_regfile_pkg;

  localparam int REG_COUNT  = 32;
  localparam int REG_ZERO   = 0;
  localparam int DEF_DATA_W = 32;
  localparam int DEF_ADDR_W = $clog2(REG_COUNT);
  localparam int DEF_CNT_W  = 32;

endpackage

// File: rtl/wb_regfile_if.sv
// rtl/wb_regfile_if.sv - MEM/WB writeback bundle, ID read ports and debug port
interface wb_regfile_if #(
  parameter int DATA_W = wb_regfile_pkg::DEF_DATA_W,
  parameter int ADDR_W = wb_regfile_pkg::DEF_ADDR_W,
  parameter int CNT_W  = wb_regfile_pkg::DEF_CNT_W
);

  logic              WWREG;
  logic              WM2REG;
  logic [DATA_W-1:0] WB_DATA;
  logic [DATA_W-1:0] WB_MEM_A;
  logic [ADDR_W-1:0] WB_REG_ADDR;
  logic [ADDR_W-1:0] RS_ADDR;
  logic [ADDR_W-1:0] RT_ADDR;
  logic [DATA_W-1:0] RS_DATA;
  logic [DATA_W-1:0] RT_DATA;
  logic [ADDR_W-1:0] DBG_ADDR;
  logic [DATA_W-1:0] DBG_DATA;
  logic [DATA_W-1:0] WB_VALUE;
  logic [CNT_W-1:0]  WB_COUNT;

  modport master (
    output WWREG, WM2REG, WB_DATA, WB_MEM_A, WB_REG_ADDR, RS_ADDR, RT_ADDR, DBG_ADDR,
    input  RS_DATA, RT_DATA, DBG_DATA, WB_VALUE, WB_COUNT
  );

  modport slave (
    input  WWREG, WM2REG, WB_DATA, WB_MEM_A, WB_REG_ADDR, RS_ADDR, RT_ADDR, DBG_ADDR,
    output RS_DATA, RT_DATA, DBG_DATA, WB_VALUE, WB_COUNT
  );

endinterface

// File: rtl/wb_regfile_wb_mux.sv
// rtl/wb_regfile_wb_mux.sv - 2:1 writeback value select, shared with the EX forwarding unit
module wb_mux #(
  parameter int DATA_W = wb_regfile_pkg::DEF_DATA_W
) (
  input  logic              sel_load_i,
  input  logic [DATA_W-1:0] load_data_i,
  input  logic [DATA_W-1:0] alu_data_i,
  output logic [DATA_W-1:0] value_o
);

  assign value_o = sel_load_i ? load_data_i : alu_data_i;

endmodule

// File: rtl/wb_regfile.sv
// rtl/wb_regfile.sv - general register file with write-before-read bypass, debug port and write counter
module wb_regfile
  import wb_regfile_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int CNT_W  = DEF_CNT_W
) (
  input  logic        clk,
  input  logic        rst,
  wb_regfile_if.slave bus
);

  localparam int                NREGS    = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] ZERO_IDX = ADDR_W'(REG_ZERO);

  logic [DATA_W-1:0] regs_q [NREGS];
  logic [DATA_W-1:0] dbg_q;
  logic [DATA_W-1:0] dbg_d;
  logic [CNT_W-1:0]  cnt_q;
  logic [CNT_W-1:0]  cnt_d;
  logic [DATA_W-1:0] wb_value;
  logic [DATA_W-1:0] rs_data;
  logic [DATA_W-1:0] rt_data;
  logic              commit;

  wb_mux #(.DATA_W(DATA_W)) u_wb_mux (
    .sel_load_i  (bus.WM2REG),
    .load_data_i (bus.WB_DATA),
    .alu_data_i  (bus.WB_MEM_A),
    .value_o     (wb_value)
  );

  // WWREG gates first so an unknown index with writeback disabled never commits
  assign commit = bus.WWREG && (bus.WB_REG_ADDR != ZERO_IDX);

  always_comb begin
    rs_data = regs_q[bus.RS_ADDR];
    if (bus.RS_ADDR == ZERO_IDX) begin
      rs_data = '0;
    end else if (commit && (bus.WB_REG_ADDR == bus.RS_ADDR)) begin
      rs_data = wb_value;
    end
  end

  always_comb begin
    rt_data = regs_q[bus.RT_ADDR];
    if (bus.RT_ADDR == ZERO_IDX) begin
      rt_data = '0;
    end else if (commit && (bus.WB_REG_ADDR == bus.RT_ADDR)) begin
      rt_data = wb_value;
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (commit) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
    dbg_d = (bus.DBG_ADDR == ZERO_IDX) ? '0 : regs_q[bus.DBG_ADDR];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) begin
        regs_q[i] <= '0;
      end
      dbg_q <= '0;
      cnt_q <= '0;
    end else begin
      dbg_q <= dbg_d;
      cnt_q <= cnt_d;
      if (commit) begin
        regs_q[bus.WB_REG_ADDR] <= wb_value;
      end
    end
  end

  assign bus.RS_DATA  = rs_data;
  assign bus.RT_DATA  = rt_data;
  assign bus.DBG_DATA = dbg_q;
  assign bus.WB_VALUE = wb_value;
  assign bus.WB_COUNT = cnt_q;

endmodule
